// File: rtl/ddr_stream_reader_if.sv
// ddr_if: client port to the DDR arbiter (Avalon-style burst read/write)
interface ddr_if;
    logic [28:0] addr;
    logic [63:0] wdata;
    logic        read;
    logic        write;
    logic [7:0]  burstcnt;
    logic [7:0]  byteenable;
    logic        acquire;
    logic        busy;
    logic        rdata_ready;
    logic [63:0] rdata;
    modport to_host (output addr, wdata, read, write, burstcnt, byteenable, acquire,
                     input busy, rdata_ready, rdata);
    modport master  (output addr, wdata, read, write, burstcnt, byteenable, acquire,
                     input busy, rdata_ready, rdata);
    modport slave   (input addr, wdata, read, write, burstcnt, byteenable, acquire,
                     output busy, rdata_ready, rdata);
endinterface

// File: rtl/ddr_stream_reader.sv
// ddr_stream_reader: streams a contiguous run of 64-bit DDR words into a local FIFO using
// credit-gated bursts and presents it on a valid/ready port.
// Define DDR_STREAM_READER_STATS_EN to add saturating stat_bursts/stat_wait counters.
module ddr_stream_reader #(
    parameter int BURST      = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [28:0] start_addr,
    input  logic [23:0] word_count,
    output logic        busy_o,
    output logic        done,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef DDR_STREAM_READER_STATS_EN
    output logic [15:0] stat_bursts,
    output logic [15:0] stat_wait,
`endif
    ddr_if.to_host      ddr
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, ACQ, REQ, DATA, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [28:0]   cur_addr_q, cur_addr_d, addr_q, addr_d;
    logic [23:0]   remaining_q, remaining_d, pending_q, pending_d;
    logic [8:0]    in_flight_q, in_flight_d;
    logic [7:0]    burstcnt_q, burstcnt_d, len;
    logic          acquire_q, acquire_d, read_q, read_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   level_q, level_d;
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic          push, pop;
    logic [31:0]   space;

    assign len        = (remaining_q < 24'(BURST)) ? remaining_q[7:0] : 8'(BURST);
    assign space      = 32'(FIFO_DEPTH) - 32'(level_q) - 32'(in_flight_q);
    assign push       = (state_q == DATA) && ddr.rdata_ready;
    assign pop        = out_valid && out_ready;
    assign out_valid  = level_q != '0;
    assign out_data   = mem_q[rd_q];
    assign busy_o     = state_q != IDLE;
    assign done       = state_q == DONE;

    assign ddr.addr       = addr_q;
    assign ddr.read       = read_q;
    assign ddr.burstcnt   = burstcnt_q;
    assign ddr.acquire    = acquire_q;
    assign ddr.write      = 1'b0;
    assign ddr.wdata      = '0;
    assign ddr.byteenable = 8'hFF;

    // Next-state: burst sequencing with FIFO credit, plus FIFO pointer bookkeeping
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        pending_d   = pending_q - 24'(pop);
        in_flight_d = in_flight_q - 9'(push);
        burstcnt_d  = burstcnt_q;
        acquire_d   = acquire_q;
        read_d      = read_q;
        wr_d        = wr_q + AW'(push);
        rd_d        = rd_q + AW'(pop);
        level_d     = level_q + (AW+1)'(push) - (AW+1)'(pop);
        case (state_q)
            IDLE: if (start) begin
                cur_addr_d  = start_addr;
                remaining_d = word_count;
                pending_d   = word_count;
                state_d     = (word_count == '0) ? DONE : ACQ;
            end
            ACQ: if (remaining_q != '0 && space >= 32'(len)) begin
                acquire_d  = 1'b1;
                read_d     = 1'b1;
                addr_d     = cur_addr_q;
                burstcnt_d = len;
                state_d    = REQ;
            end
            REQ: if (!ddr.busy) begin
                cur_addr_d  = cur_addr_q + 29'(burstcnt_q);
                remaining_d = remaining_q - 24'(burstcnt_q);
                in_flight_d = in_flight_q + 9'(burstcnt_q);
                read_d      = 1'b0;
                state_d     = DATA;
            end
            DATA: if (push && in_flight_q == 9'd1) begin
                acquire_d = 1'b0;
                state_d   = (remaining_q != '0) ? ACQ : DRAIN;
            end
            DRAIN: if (pop && pending_q == 24'd1) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            pending_q   <= '0;
            in_flight_q <= '0;
            burstcnt_q  <= '0;
            acquire_q   <= 1'b0;
            read_q      <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            in_flight_q <= in_flight_d;
            burstcnt_q  <= burstcnt_d;
            acquire_q   <= acquire_d;
            read_q      <= read_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            level_q     <= level_d;
        end
    end

    // FIFO storage; contents need no reset because level gates visibility
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= ddr.rdata;
    end

`ifdef DDR_STREAM_READER_STATS_EN
    logic [15:0] bursts_q, bursts_d, wait_q, wait_d;

    // Saturating counters, cleared on every accepted start
    always_comb begin
        bursts_d = bursts_q;
        wait_d   = wait_q;
        if (state_q == IDLE && start) begin
            bursts_d = '0;
            wait_d   = '0;
        end else begin
            if (state_q == REQ && !ddr.busy && bursts_q != 16'hFFFF) bursts_d = bursts_q + 16'd1;
            if (read_q && ddr.busy && wait_q != 16'hFFFF) wait_d = wait_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bursts_q <= '0;
            wait_q   <= '0;
        end else begin
            bursts_q <= bursts_d;
            wait_q   <= wait_d;
        end
    end

    assign stat_bursts = bursts_q;
    assign stat_wait   = wait_q;
`endif
endmodule

// File: tb/tb_ddr_stream_reader.sv
// tb_ddr_stream_reader: directed checks of ddr_stream_reader against a behavioural arbiter/DDR model
module tb_ddr_stream_reader;
    localparam int BURST = 16;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [28:0] start_addr = '0;
    logic [23:0] word_count = '0;
    logic        out_ready = 1'b0;
    logic        busy_o, done, out_valid;
    logic [63:0] out_data;
`ifdef DDR_STREAM_READER_STATS_EN
    logic [15:0] stat_bursts, stat_wait;
`endif

    int n_chk = 0;
    int n_err = 0;
    int busy_cycles = 2;
    int wait_cnt = 0;
    int nb, delivered, popped, ndone, acq_seen, unstable, acq_drop, ovf;
    int pops_at [32];
    int blen [32];
    logic [28:0] baddr [32];
    logic [28:0] beats [$];
    logic [28:0] exp_addr, prev_addr;
    logic [7:0]  prev_cnt;
    logic        prev_read = 1'b0;

    ddr_if ddr();

    ddr_stream_reader #(.BURST(BURST), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .word_count(word_count), .busy_o(busy_o), .done(done), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef DDR_STREAM_READER_STATS_EN
        .stat_bursts(stat_bursts), .stat_wait(stat_wait),
`endif
        .ddr(ddr)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [28:0] a);
        return {3'b101, ~a, 3'b011, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear(input logic [28:0] a);
        nb = 0; delivered = 0; popped = 0; ndone = 0;
        acq_seen = 0; unstable = 0; acq_drop = 0; ovf = 0;
        exp_addr = a;
    endtask

    task automatic pulse(input logic [28:0] a, input logic [23:0] n);
        start_addr = a;
        word_count = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (busy_o && c < bound) begin
            @(negedge clk);
            c++;
        end
        check("timeout", 64'(busy_o), 64'd0);
    endtask

    task automatic run(input logic [28:0] a, input logic [23:0] n);
        clear(a);
        pulse(a, n);
        wait_idle(4000);
    endtask

    // Arbiter/DDR model and consumer scoreboard, acting just after each falling edge
    initial begin
        ddr.busy = 1'b1;
        ddr.rdata_ready = 1'b0;
        ddr.rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                beats.delete();
                ddr.busy = 1'b1;
                ddr.rdata_ready = 1'b0;
                wait_cnt = 0;
                prev_read = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    check("data", out_data, pat(exp_addr));
                    exp_addr = exp_addr + 29'd1;
                    popped++;
                end
                if (done) ndone++;
                if (ddr.acquire) acq_seen++;
                if ((beats.size() != 0 || ddr.read) && !ddr.acquire) acq_drop++;
                if (ddr.read && prev_read && (ddr.addr != prev_addr || ddr.burstcnt != prev_cnt)) unstable++;
                prev_read = ddr.read;
                prev_addr = ddr.addr;
                prev_cnt = ddr.burstcnt;
                ddr.rdata_ready = beats.size() != 0;
                if (beats.size() != 0) begin
                    ddr.rdata = pat(beats.pop_front());
                    delivered++;
                    if (delivered - popped > DEPTH) ovf++;
                end
                ddr.busy = 1'b1;
                if (!ddr.read) wait_cnt = 0;
                else if (wait_cnt < busy_cycles) wait_cnt++;
                else begin
                    ddr.busy = 1'b0;
                    wait_cnt = 0;
                    if (nb < 32) begin
                        baddr[nb] = ddr.addr;
                        blen[nb] = int'(ddr.burstcnt);
                        pops_at[nb] = popped;
                    end
                    nb++;
                    for (int i = 0; i < int'(ddr.burstcnt); i++) beats.push_back(ddr.addr + 29'(i));
                end
            end
        end
    end

    initial begin
        clear('0);
        repeat (3) @(negedge clk);
        check("rst_acquire", 64'(ddr.acquire), 64'd0);
        check("rst_read", 64'(ddr.read), 64'd0);
        check("rst_write", 64'(ddr.write), 64'd0);
        check("rst_burstcnt", 64'(ddr.burstcnt), 64'd0);
        check("rst_byteenable", 64'(ddr.byteenable), 64'hFF);
        check("rst_addr", 64'(ddr.addr), 64'd0);
        check("rst_wdata", ddr.wdata, 64'd0);
        check("rst_busy_o", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 40 words in bursts of 16,16,8
        out_ready = 1'b1;
        run(29'h100, 24'd40);
        check("t1_nb", 64'(nb), 64'd3);
        check("t1_addr0", 64'(baddr[0]), 64'h100);
        check("t1_addr1", 64'(baddr[1]), 64'h110);
        check("t1_addr2", 64'(baddr[2]), 64'h120);
        check("t1_len0", 64'(blen[0]), 64'd16);
        check("t1_len1", 64'(blen[1]), 64'd16);
        check("t1_len2", 64'(blen[2]), 64'd8);
        check("t1_popped", 64'(popped), 64'd40);
        check("t1_done", 64'(ndone), 64'd1);
        check("t1_ovf", 64'(ovf), 64'd0);
        check("t1_acq_drop", 64'(acq_drop), 64'd0);
`ifdef DDR_STREAM_READER_STATS_EN
        check("t1_stat_bursts", 64'(stat_bursts), 64'd3);
`endif

        // zero-length transfer
        clear(29'h77);
        pulse(29'h77, 24'd0);
        check("t2_done", 64'(done), 64'd1);
        check("t2_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        check("t2_done_end", 64'(done), 64'd0);
        check("t2_busy_end", 64'(busy_o), 64'd0);
        repeat (3) @(negedge clk);
        check("t2_acq", 64'(acq_seen), 64'd0);
        check("t2_nb", 64'(nb), 64'd0);
        check("t2_popped", 64'(popped), 64'd0);
        check("t2_out_valid", 64'(out_valid), 64'd0);

        // stalled consumer: credit limits to four bursts
        clear(29'h4000);
        out_ready = 1'b0;
        pulse(29'h4000, 24'd200);
        repeat (200) @(negedge clk);
        check("t3_nb_stall", 64'(nb), 64'd4);
        check("t3_delivered", 64'(delivered), 64'd64);
        check("t3_read", 64'(ddr.read), 64'd0);
        check("t3_acquire", 64'(ddr.acquire), 64'd0);
        check("t3_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_idle(4000);
        check("t3_nb", 64'(nb), 64'd13);
        check("t3_credit", 64'(pops_at[4] >= 16), 64'd1);
        check("t3_last_addr", 64'(baddr[12]), 64'h40C0);
        check("t3_last_len", 64'(blen[12]), 64'd8);
        check("t3_popped", 64'(popped), 64'd200);
        check("t3_done", 64'(ndone), 64'd1);
        check("t3_ovf", 64'(ovf), 64'd0);

        // long arbiter stall
        busy_cycles = 30;
        run(29'h2000, 24'd16);
        busy_cycles = 2;
        check("t4_stable", 64'(unstable), 64'd0);
        check("t4_acq_drop", 64'(acq_drop), 64'd0);
        check("t4_nb", 64'(nb), 64'd1);
        check("t4_popped", 64'(popped), 64'd16);
`ifdef DDR_STREAM_READER_STATS_EN
        check("t4_stat_wait", 64'(stat_wait), 64'd30);
        check("t4_stat_bursts", 64'(stat_bursts), 64'd1);
`endif

        // top-of-memory start, with a second start ignored mid-transfer
        clear(29'h1FFFFFF8);
        pulse(29'h1FFFFFF8, 24'd16);
        repeat (5) @(negedge clk);
        pulse(29'h555, 24'd8);
        wait_idle(4000);
        check("t5_nb", 64'(nb), 64'd1);
        check("t5_addr0", 64'(baddr[0]), 64'h1FFFFFF8);
        check("t5_popped", 64'(popped), 64'd16);
        check("t5_done", 64'(ndone), 64'd1);
        run(29'h1FFFFFF0, 24'd40);
        check("t5_wrap_addr1", 64'(baddr[1]), 64'h0);
        check("t5_wrap_addr2", 64'(baddr[2]), 64'h10);
        check("t5_wrap_popped", 64'(popped), 64'd40);

        // reset in the middle of a burst
        clear(29'h3000);
        pulse(29'h3000, 24'd16);
        begin
            int c = 0;
            while (delivered < 5 && c < 500) begin
                @(posedge clk);
                c++;
            end
        end
        check("t6_reached_beat5", 64'(delivered), 64'd5);
        #2 reset_n = 1'b0;
        #1;
        check("t6_acquire", 64'(ddr.acquire), 64'd0);
        check("t6_read", 64'(ddr.read), 64'd0);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_busy", 64'(busy_o), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run(29'h3100, 24'd20);
        check("t6_nb", 64'(nb), 64'd2);
        check("t6_addr1", 64'(baddr[1]), 64'h3110);
        check("t6_len1", 64'(blen[1]), 64'd4);
        check("t6_popped", 64'(popped), 64'd20);
        check("t6_done", 64'(ndone), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
